bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-port arbiter and sequencer for the shared `data_bus` memory port. Accepts load/store requests from the CPU (port 0) and from a secondary master such as the boot-copy/DMA engine (port 1), serialises them onto the single `data_bus` interface, and returns read data, exception status and a one-cycle acknowledge to the winning requester. It sits between `zipocpu` / loader logic and `data_bus` inside `ziposoc`.

## Interface

- `BUS_LATENCY`, default 1: cycles `data_bus` signals are held before read data/exception are sampled (1..15).
- `ADDR_W`, default 32: address width.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  request from port 0 (CPU) / port 1 (loader).
- `rw0` / `rw1`  in  1  1 = write, 0 = read.
- `len0` / `len1`  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (passed through).
- `addr0` / `addr1`  in  ADDR_W  byte address.
- `wdata0` / `wdata1`  in  32  write data, right-aligned.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  32  read data, valid in the ack cycle (shared by both ports).
- `err`  out  1  `data_bus` exception for the completing access, valid in the ack cycle.
- `busy`  out  1  high while a transaction is in ACCESS or ACK.
- `bus_rw`  out  1  to `data_bus.rw`.
- `bus_len`  out  2  to `data_bus.len`.
- `bus_addr`  out  ADDR_W  to `data_bus.addr`.
- `bus_wdata`  out  32  to `data_bus.write`.
- `bus_rdata`  in  32  from `data_bus.read`.
- `bus_exc`  in  1  from `data_bus.exception`.

## Operation

- States: IDLE, ACCESS, ACK.
- IDLE: if any `req` high at posedge, pick winner, latch its `rw/len/addr/wdata` into `bus_*` registers, record `owner`, load down-counter with `BUS_LATENCY-1`, go ACCESS. No request: stay IDLE.
- ACCESS: `bus_*` held constant. Counter decrements each cycle; when counter = 0, register `bus_rdata` into `rdata` and `bus_exc` into `err`, go ACK.
- ACK: `ack<owner>` high for exactly this cycle, `bus_rw` forced 0; next state IDLE.
- Outside ACCESS, `bus_rw` = 0 (no spurious writes); `bus_addr/len/wdata` hold last value.
- Requester must hold `req` and fields stable until its ack. Fields are latched in IDLE; changes afterwards are ignored. A `req` deasserted mid-transaction does not abort it; ack still pulses.
- Read data for writes: `rdata` still updated from `bus_rdata` (don't-care for requester). `err` for writes reflects `bus_exc`.
- `len` = 11 forwarded unchanged; `data_bus` raises the exception.
- Reset (any time, including mid-ACCESS): state IDLE, counter 0, `owner` 0, last-grant = port 1, all outputs 0; in-flight transaction dropped, no ack issued.

## Timing

- Request sampled at edge T in IDLE → `bus_*` valid from T+1 for `BUS_LATENCY` cycles → `ack` high in cycle T+`BUS_LATENCY`+1 → IDLE at T+`BUS_LATENCY`+2.
- Request-to-ack latency `BUS_LATENCY`+1; throughput one access per `BUS_LATENCY`+2 cycles.
- `busy` high from T+1 through the ack cycle inclusive.
- Simultaneous `req0` and `req1` in IDLE: resolved per Configuration; loser waits, granted at the next IDLE.
- No combinational path from any `req*` input to any output.

## Configuration

- `BUS_ARB_ROUND_ROBIN_EN` defined: round-robin; on contention the port not granted last wins; last-grant reset value port 1 (port 0 wins first contention).
- Not defined: fixed priority, port 0 always wins; port 1 may starve under continuous port-0 traffic. Last-grant register not implemented.

## Test plan

- Reset: drive `rst_n`=0 with `req0`=1 → all outputs 0, `bus_rw`=0; release → first grant one cycle later.
- Single read, `BUS_LATENCY`=1: `req0`, rw=0, len=00, addr=0x10, model returns 0xA5 → `bus_addr`=0x10 at T+1, `ack0` at T+2, `rdata`=0xA5, `err`=0, `ack1` never.
- Single write, `BUS_LATENCY`=3: `req1`, rw=1, addr=0x20, wdata=0xE0 → `bus_rw`=1 for exactly 3 cycles, `ack1` at T+4, then `bus_rw`=0.
- Contention: `req0`,`req1` held high for 4 transactions → with macro grants 0,1,0,1; without macro 0,0,0,0.
- Exception: model asserts `bus_exc` for addr beyond memory end → `err`=1 in ack cycle only, next transaction `err`=0.
- Reset mid-ACCESS (`BUS_LATENCY`=4, assert `rst_n`=0 at T+2) → no ack, `busy`=0, `bus_rw`=0 immediately; held request regranted after release.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port arbiter/sequencer serialising CPU (port 0) and loader (port 1) accesses onto data_bus.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module bus_arbiter #(
    parameter int BUS_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [1:0]        len0,
    input  logic [1:0]        len1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic              bus_rw,
    output logic [1:0]        bus_len,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_exc
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(BUS_LATENCY - 1);

    state_t     state;
    logic [3:0] count;
    logic       owner;
    logic       winner;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On contention the port not granted last wins; a lone requester always wins.
    always_comb begin
        // NOTE: default assignment first so every path drives winner and no latch is inferred.
        winner = ~req0;
        if (req0 && req1) begin
            winner = ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            last_grant <= winner;
        end
    end
`else
    // Port 0 always wins; port 1 is chosen only when port 0 is not requesting.
    assign winner = ~req0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            owner     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            bus_rw    <= 1'b0;
            bus_len   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= winner;
                        bus_rw    <= winner ? rw1 : rw0;
                        bus_len   <= winner ? len1 : len0;
                        bus_addr  <= winner ? addr1 : addr0;
                        bus_wdata <= winner ? wdata1 : wdata0;
                        count     <= LAT_M1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        rdata  <= bus_rdata;
                        err    <= bus_exc;
                        bus_rw <= 1'b0;
                        ack0   <= ~owner;
                        ack1   <= owner;
                        state  <= ACK;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ACK: begin
                    // err is only meaningful alongside ack, so it drops with it.
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations plus a
// randomized two-port run compared every cycle against a cycle-schedule reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (BUS_LATENCY = LAT)
    logic        req0, req1, rw0, rw1;
    logic [1:0]  len0, len1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err, busy, bus_rw, bus_exc;
    logic [1:0]  bus_len;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;

    // Second DUT (BUS_LATENCY = 1)
    logic        s_req0, s_req1, s_rw0, s_rw1;
    logic [1:0]  s_len0, s_len1;
    logic [31:0] s_addr0, s_addr1, s_wdata0, s_wdata1;
    logic        s_ack0, s_ack1, s_err, s_busy, s_bus_rw, s_bus_exc;
    logic [1:0]  s_bus_len;
    logic [31:0] s_rdata, s_bus_addr, s_bus_wdata, s_bus_rdata;

    int n_pass  = 0;
    int n_total = 0;

    // Memory model: read data derived from the address, exception past 0x1000 or for len 11.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], 8'h00, a[7:0] ^ 8'hB5};
    endfunction

    function automatic logic exc_f(input logic [31:0] a, input logic [1:0] l);
        return (a >= 32'h0000_1000) || (l == 2'b11);
    endfunction

    assign bus_rdata   = mem_f(bus_addr);
    assign bus_exc     = exc_f(bus_addr, bus_len);
    assign s_bus_rdata = mem_f(s_bus_addr);
    assign s_bus_exc   = exc_f(s_bus_addr, s_bus_len);

    bus_arbiter #(.BUS_LATENCY(LAT), .ADDR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .len0(len0), .len1(len1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_exc(bus_exc)
    );

    bus_arbiter #(.BUS_LATENCY(1), .ADDR_W(32)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0(s_req0), .req1(s_req1), .rw0(s_rw0), .rw1(s_rw1),
        .len0(s_len0), .len1(s_len1), .addr0(s_addr0), .addr1(s_addr1),
        .wdata0(s_wdata0), .wdata1(s_wdata1),
        .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .err(s_err), .busy(s_busy),
        .bus_rw(s_bus_rw), .bus_len(s_bus_len), .bus_addr(s_bus_addr), .bus_wdata(s_bus_wdata),
        .bus_rdata(s_bus_rdata), .bus_exc(s_bus_exc)
    );

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: a transaction is a schedule of cycles counted from its grant.
    // Cycles 1..LAT drive the bus, cycle LAT+1 is the ack cycle, then the arbiter is free.
    int          phase;
    logic        m_own, m_last, m_rw, m_err;
    logic [1:0]  m_len;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic logic pick(input logic r0, input logic r1, input logic last);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        if (r0 && r1) return ~last;
`else
        if (r0 && r1) return 1'b0;
`endif
        return ~r0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 0;
            m_own   <= 1'b0;
            m_last  <= 1'b1;
            m_rw    <= 1'b0;
            m_err   <= 1'b0;
            m_len   <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else if (phase == 0) begin
            if (req0 || req1) begin
                m_own   <= pick(req0, req1, m_last);
                m_last  <= pick(req0, req1, m_last);
                m_rw    <= pick(req0, req1, m_last) ? rw1 : rw0;
                m_len   <= pick(req0, req1, m_last) ? len1 : len0;
                m_addr  <= pick(req0, req1, m_last) ? addr1 : addr0;
                m_wdata <= pick(req0, req1, m_last) ? wdata1 : wdata0;
                phase   <= 1;
            end
        end else if (phase == LAT + 1) begin
            phase <= 0;
            m_err <= 1'b0;
        end else begin
            if (phase == LAT) begin
                m_rdata <= mem_f(m_addr);
                m_err   <= exc_f(m_addr, m_len);
            end
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        check("model",
              {busy, ack0, ack1, bus_rw, err, bus_len, bus_addr, bus_wdata, rdata},
              {phase != 0,
               (phase == LAT + 1) && !m_own,
               (phase == LAT + 1) && m_own,
               (phase >= 1) && (phase <= LAT) && m_rw,
               m_err, m_len, m_addr, m_wdata, m_rdata});
    end

    logic s_ack1_seen = 1'b0;
    always @(negedge clk) if (s_ack1) s_ack1_seen <= 1'b1;

    // Waits for the given port's ack; k is the negedge index (1 = first cycle after the
    // call) at which it was seen, 0 on timeout. Drops the request in the ack cycle.
    task automatic wait_ack(input bit port, output int k, output int rw_cnt);
        k = 0;
        rw_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus_rw) rw_cnt++;
            if (port ? ack1 : ack0) begin
                k = i;
                break;
            end
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int k, rwc, n_acks;
    int got[4];
    int exp_order[4];
    int gap[2];
    bit pending[2];

    initial begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        {req0, req1, rw0, rw1, len0, len1, addr0, addr1, wdata0, wdata1} = '0;
        {s_req0, s_req1, s_rw0, s_rw1, s_len0, s_len1, s_addr0, s_addr1, s_wdata0, s_wdata1} = '0;

        // Reset with a pending request: everything stays 0, grant one edge after release.
        req0  = 1'b1;
        addr0 = 32'h44;
        len0  = 2'b10;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, ack0, ack1, bus_rw, err, bus_len, bus_addr, bus_wdata, rdata}, '0);
        check("reset_outputs_l1", {s_busy, s_ack0, s_ack1, s_bus_rw, s_err, s_bus_addr, s_rdata}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_grant", {busy, bus_addr}, {1'b1, 32'h44});
        wait_ack(0, k, rwc);
        check("release_ack_lat", k, LAT);

        // Single write on port 1: bus_rw high for exactly LAT cycles, ack at T+LAT+1.
        @(negedge clk);
        req1   = 1'b1;
        rw1    = 1'b1;
        len1   = 2'b00;
        addr1  = 32'h20;
        wdata1 = 32'hE0;
        wait_ack(1, k, rwc);
        check("wr_ack_lat", k, LAT + 1);
        check("wr_rw_cycles", rwc, LAT);
        check("wr_bus_fields", {bus_addr, bus_wdata}, {32'h20, 32'hE0});
        @(negedge clk);
        check("wr_after_ack", {bus_rw, busy, ack1}, 3'b000);
        rw1 = 1'b0;

        // Exception: only in the ack cycle; the next access is clean.
        req0  = 1'b1;
        addr0 = 32'h2000;
        wait_ack(0, k, rwc);
        check("exc_err", {k, err}, {32'(LAT + 1), 1'b1});
        @(negedge clk);
        check("exc_err_cleared", err, 1'b0);
        req0  = 1'b1;
        addr0 = 32'h30;
        wait_ack(0, k, rwc);
        check("post_exc_read", {err, rdata}, {1'b0, 32'h0030_0085});

        // BUS_LATENCY = 1 instance: single read from 0x10.
        @(negedge clk);
        s_req0  = 1'b1;
        s_addr0 = 32'h10;
        s_len0  = 2'b00;
        @(negedge clk);
        check("l1_t1", {s_busy, s_bus_addr, s_ack0, s_bus_rw}, {1'b1, 32'h10, 1'b0, 1'b0});
        @(negedge clk);
        check("l1_ack", {s_ack0, s_ack1, s_err, s_rdata}, {1'b1, 1'b0, 1'b0, 32'h0010_00A5});
        s_req0 = 1'b0;
        @(negedge clk);
        check("l1_idle", {s_ack0, s_busy}, 2'b00);

        // Reset two edges into ACCESS: no ack, immediate idle outputs, request regranted.
        req0  = 1'b1;
        addr0 = 32'h50;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("midrst_outputs", {busy, bus_rw, ack0, ack1}, 4'b0000);
        @(negedge clk);
        check("midrst_no_ack", {ack0, busy}, 2'b00);
        rst_n = 1'b1;
        wait_ack(0, k, rwc);
        check("midrst_regrant", {k, rdata}, {32'(LAT + 1), 32'h0050_00E5});

        // Contention from reset: both ports held for four transactions.
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h100;
        addr1 = 32'h200;
        got   = '{9, 9, 9, 9};
        n_acks = 0;
        for (int i = 0; i < 80 && n_acks < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                got[n_acks] = ack1 ? 1 : 0;
                n_acks++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) check("contention_grant", got[i], exp_order[i]);

        // Randomized traffic on both ports, checked by the model every cycle.
        pending = '{0, 0};
        gap     = '{0, 0};
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (pending[p]) begin
                    if (p == 0 ? ack0 : ack1) begin
                        pending[p] = 1'b0;
                        gap[p] = $urandom_range(3, 0);
                        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else if ($urandom_range(1, 0) == 1) begin
                    pending[p] = 1'b1;
                    if (p == 0) begin
                        req0 = 1'b1; rw0 = 1'($urandom); len0 = 2'($urandom);
                        addr0 = $urandom_range(32'h17FF, 0); wdata0 = $urandom;
                    end else begin
                        req1 = 1'b1; rw1 = 1'($urandom); len1 = 2'($urandom);
                        addr1 = $urandom_range(32'h17FF, 0); wdata1 = $urandom;
                    end
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("l1_ack1_never", s_ack1_seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
